// File: rtl/dm_ctrl_pkg.sv
// Shared definitions for the data-memory controller: DM access type codes,
// controller state encoding and default memory depth.
package dm_ctrl_pkg;

  localparam int unsigned DM_DEPTH = 1024;

  localparam logic [2:0] DM_w  = 3'd0;
  localparam logic [2:0] DM_h  = 3'd1;
  localparam logic [2:0] DM_hu = 3'd2;
  localparam logic [2:0] DM_b  = 3'd3;
  localparam logic [2:0] DM_bu = 3'd4;

  typedef enum logic [1:0] {
    DMC_INIT  = 2'd0,
    DMC_IDLE  = 2'd1,
    DMC_ISSUE = 2'd2,
    DMC_RESP  = 2'd3
  } dmc_state_t;

endpackage

// File: rtl/dm_rr_pick.sv
// Two-requester round-robin picker: a lone valid is granted, and on a tie
// the port that was not granted last time wins.
module dm_rr_pick (
  input  logic valid0,
  input  logic valid1,
  input  logic last,
  output logic grant0,
  output logic grant1
);

  assign grant0 = valid0 & (~valid1 | last);
  assign grant1 = valid1 & (~valid0 | ~last);

endmodule

// File: rtl/dm_ctrl.sv
// Data-memory sequencer/arbiter: zero-fills DM after reset, then serves
// single-beat loads/stores from two requesters with a registered response.
module dm_ctrl
  import dm_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH      = DM_DEPTH,
  parameter bit          INIT_CLEAR = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_we,
  input  logic [2:0]  req0_type,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic [31:0] req0_pc,
  output logic        rsp0_valid,
  output logic        rsp0_err,
  output logic [31:0] rsp0_rdata,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_we,
  input  logic [2:0]  req1_type,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  input  logic [31:0] req1_pc,
  output logic        rsp1_valid,
  output logic        rsp1_err,
  output logic [31:0] rsp1_rdata,
  output logic        dm_wr,
  output logic [2:0]  dm_type,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  output logic [31:0] dm_pc,
  input  logic [31:0] dm_rdata,
  output logic        init_done
);

  localparam int unsigned CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

  dmc_state_t state, state_nx;

  // Reset release is sampled here: nothing acts until the first edge with reset high.
  logic          active;
  logic [CW-1:0] cnt;
  logic          last_grant;
  logic          grant0, grant1, hs, init_drv;

  logic          sel_we, sel_err;
  logic [2:0]    sel_type;
  logic [31:0]   sel_addr, sel_wdata, sel_pc;

  logic          l_we, l_err, l_port;
  logic [2:0]    l_type;
  logic [31:0]   l_addr, l_wdata, l_pc;

  dm_rr_pick u_pick (
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .last   (last_grant),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  assign req0_ready = (state == DMC_IDLE) & active & grant0;
  assign req1_ready = (state == DMC_IDLE) & active & grant1;
  assign hs         = req0_ready | req1_ready;
  assign init_drv   = (state == DMC_INIT) & active;

  assign sel_we    = grant1 ? req1_we    : req0_we;
  assign sel_type  = grant1 ? req1_type  : req0_type;
  assign sel_addr  = grant1 ? req1_addr  : req0_addr;
  assign sel_wdata = grant1 ? req1_wdata : req0_wdata;
  assign sel_pc    = grant1 ? req1_pc    : req0_pc;

  always_comb begin
    sel_err = 1'b0;
    case (sel_type)
      DM_w:    sel_err = (sel_addr[1:0] != 2'b00);
      DM_h:    sel_err = sel_addr[0];
      DM_hu:   sel_err = sel_addr[0] | sel_we;
      DM_b:    sel_err = 1'b0;
      DM_bu:   sel_err = sel_we;
      default: sel_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= INIT_CLEAR ? DMC_INIT : DMC_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      DMC_INIT:  if (init_drv && cnt == CNT_LAST) state_nx = DMC_IDLE;
      DMC_IDLE:  if (hs) state_nx = DMC_ISSUE;
      DMC_ISSUE: state_nx = DMC_RESP;
      DMC_RESP:  state_nx = DMC_IDLE;
      default:   state_nx = DMC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active     <= 1'b0;
      cnt        <= '0;
      last_grant <= 1'b1;
      init_done  <= 1'b0;
      l_we       <= 1'b0;
      l_err      <= 1'b0;
      l_port     <= 1'b0;
      l_type     <= '0;
      l_addr     <= '0;
      l_wdata    <= '0;
      l_pc       <= '0;
      rsp0_valid <= 1'b0;
      rsp0_err   <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_valid <= 1'b0;
      rsp1_err   <= 1'b0;
      rsp1_rdata <= '0;
    end else begin
      active     <= 1'b1;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      if (init_drv) cnt <= cnt + CW'(1);
      if (active && state_nx != DMC_INIT) init_done <= 1'b1;
      if (hs) begin
        l_we       <= sel_we;
        l_err      <= sel_err;
        l_port     <= grant1;
        l_type     <= sel_type;
        l_addr     <= sel_addr;
        l_wdata    <= sel_wdata;
        l_pc       <= sel_pc;
        last_grant <= grant1;
      end
      // Response is captured at the ISSUE edge, so rsp_* never see dm_rdata combinationally.
      if (state == DMC_ISSUE) begin
        if (l_port) begin
          rsp1_valid <= 1'b1;
          rsp1_err   <= l_err;
          rsp1_rdata <= (l_we | l_err) ? '0 : dm_rdata;
        end else begin
          rsp0_valid <= 1'b1;
          rsp0_err   <= l_err;
          rsp0_rdata <= (l_we | l_err) ? '0 : dm_rdata;
        end
      end
    end
  end

  assign dm_wr   = init_drv | ((state == DMC_ISSUE) & l_we & ~l_err);
  assign dm_type = init_drv ? DM_w : l_type;
  assign dm_addr = init_drv ? (32'(cnt) << 2) : l_addr;
  assign dm_wd   = init_drv ? '0 : l_wdata;
  assign dm_pc   = init_drv ? '0 : l_pc;

endmodule

// File: tb/tb_dm_ctrl.sv
// Self-checking bench for dm_ctrl: a behavioural DM device plus a byte-level
// reference memory predict every response, error flag and write.
module tb_dm_ctrl;
  import dm_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req0_we, rsp0_valid, rsp0_err;
  logic [2:0]  req0_type;
  logic [31:0] req0_addr, req0_wdata, req0_pc, rsp0_rdata;
  logic        req1_valid, req1_ready, req1_we, rsp1_valid, rsp1_err;
  logic [2:0]  req1_type;
  logic [31:0] req1_addr, req1_wdata, req1_pc, rsp1_rdata;
  logic        dm_wr, init_done;
  logic [2:0]  dm_type;
  logic [31:0] dm_addr, dm_wd, dm_pc, dm_rdata;

  dm_ctrl #(.DEPTH(1024), .INIT_CLEAR(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_type(req0_type), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_pc(req0_pc), .rsp0_valid(rsp0_valid), .rsp0_err(rsp0_err),
    .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_type(req1_type), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_pc(req1_pc), .rsp1_valid(rsp1_valid), .rsp1_err(rsp1_err),
    .rsp1_rdata(rsp1_rdata),
    .dm_wr(dm_wr), .dm_type(dm_type), .dm_addr(dm_addr), .dm_wd(dm_wd),
    .dm_pc(dm_pc), .dm_rdata(dm_rdata), .init_done(init_done)
  );

  always #5 clk = ~clk;

  // DM device: word array, lane writes, combinational extended reads.
  logic [31:0] dm_mem [1024];
  logic        scramble = 1'b0;
  logic [31:0] rd_word;
  logic [15:0] rd_half;
  logic [7:0]  rd_byte;

  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < 1024; i++) dm_mem[i] <= $urandom;
    end else if (dm_wr) begin
      case (dm_type)
        DM_w:        dm_mem[dm_addr[11:2]] <= dm_wd;
        DM_h, DM_hu: dm_mem[dm_addr[11:2]][{dm_addr[1], 4'b0} +: 16] <= dm_wd[15:0];
        default:     dm_mem[dm_addr[11:2]][{dm_addr[1:0], 3'b0} +: 8] <= dm_wd[7:0];
      endcase
    end
  end

  assign rd_word = dm_mem[dm_addr[11:2]];
  assign rd_half = rd_word[{dm_addr[1], 4'b0} +: 16];
  assign rd_byte = rd_word[{dm_addr[1:0], 3'b0} +: 8];

  always_comb begin
    dm_rdata = '0;
    case (dm_type)
      DM_w:    dm_rdata = rd_word;
      DM_h:    dm_rdata = {{16{rd_half[15]}}, rd_half};
      DM_hu:   dm_rdata = {16'h0, rd_half};
      DM_b:    dm_rdata = {{24{rd_byte[7]}}, rd_byte};
      DM_bu:   dm_rdata = {24'h0, rd_byte};
      default: dm_rdata = '0;
    endcase
  end

  int wr_seen = 0;
  always @(negedge clk) if (dm_wr) wr_seen <= wr_seen + 1;

  // Reference model: flat byte memory and arithmetic legality rules.
  logic [7:0] ref_mem [4096];
  int  checks = 0;
  int  fails = 0;
  bit  mdl_last = 1'b1;

  task automatic ref_clear();
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
  endtask

  function automatic int unsigned ref_size(logic [2:0] ty);
    if (ty == DM_w) return 4;
    if (ty == DM_h || ty == DM_hu) return 2;
    if (ty == DM_b || ty == DM_bu) return 1;
    return 0;
  endfunction

  function automatic bit ref_err(logic we, logic [2:0] ty, logic [31:0] a);
    int unsigned sz = ref_size(ty);
    if (sz == 0) return 1'b1;
    if ((a % sz) != 0) return 1'b1;
    if (we && (ty == DM_hu || ty == DM_bu)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(logic [2:0] ty, logic [31:0] a);
    int unsigned sz = ref_size(ty);
    int unsigned b = {20'h0, a[11:0]};
    logic [31:0] v = '0;
    for (int k = 0; k < int'(sz); k++) v[8*k +: 8] = ref_mem[b + k];
    if (ty == DM_h && v[15]) v[31:16] = '1;
    if (ty == DM_b && v[7])  v[31:8]  = '1;
    return v;
  endfunction

  task automatic ref_store(logic [2:0] ty, logic [31:0] a, logic [31:0] d);
    int unsigned sz = ref_size(ty);
    int unsigned b = {20'h0, a[11:0]};
    for (int k = 0; k < int'(sz); k++) ref_mem[b + k] = d[8*k +: 8];
  endtask

  function automatic logic rdy(int p);  return (p != 0) ? req1_ready : req0_ready; endfunction
  function automatic logic rspv(int p); return (p != 0) ? rsp1_valid : rsp0_valid; endfunction
  function automatic logic rspe(int p); return (p != 0) ? rsp1_err   : rsp0_err;   endfunction
  function automatic logic [31:0] rspd(int p); return (p != 0) ? rsp1_rdata : rsp0_rdata; endfunction

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic drive(input int p, input logic v, input logic we, input logic [2:0] ty,
                       input logic [31:0] a, input logic [31:0] d);
    if (p != 0) begin
      req1_valid = v; req1_we = we; req1_type = ty; req1_addr = a; req1_wdata = d; req1_pc = a ^ 32'h8000;
    end else begin
      req0_valid = v; req0_we = we; req0_type = ty; req0_addr = a; req0_wdata = d; req0_pc = a ^ 32'h4000;
    end
  endtask

  // One transaction on port p; returns response, latency in cycles from handshake,
  // whether the pulse lasted one cycle, and how many DM writes it caused.
  task automatic txn(input int p, input logic we, input logic [2:0] ty, input logic [31:0] a,
                     input logic [31:0] d, output logic e, output logic [31:0] rd,
                     output int lat, output bit one_pulse, output int wrs);
    int n = 0;
    int w0;
    drive(p, 1'b1, we, ty, a, d);
    #1;
    while (!rdy(p) && n < 100) begin step(); n++; end
    if (!rdy(p)) begin
      checks++; fails++;
      $display("FAIL hs_timeout port%0d: ready never rose within %0d cycles", p, n);
      drive(p, 1'b0, we, ty, a, d);
      e = 1'bx; rd = 'x; lat = -1; one_pulse = 0; wrs = -1;
      return;
    end
    mdl_last = (p != 0);
    w0 = wr_seen;
    step();
    drive(p, 1'b0, we, ty, a, d);
    lat = 1;
    while (!rspv(p) && lat < 8) begin step(); lat++; end
    e = rspe(p);
    rd = rspd(p);
    step();
    one_pulse = !rspv(p);
    wrs = wr_seen - w0;
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (!init_done && n < 3000) begin step(); n++; end
    checks++;
    if (init_done !== 1'b1) begin fails++; $display("FAIL %s_init_timeout: init_done=%b after %0d cycles, want 1", tag, init_done, n); end
  endtask

  task automatic test_reset();
    int idx = 0, bad = 0, n = 0;
    logic e; logic [31:0] rd; int lat, wrs; bit op;
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, DM_w, '0, '0);
    drive(1, 1'b0, 1'b0, DM_w, '0, '0);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({dm_wr, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, init_done} !== 8'h00) begin
      fails++; $display("FAIL reset_ctrl: got %b want 00000000",
        {dm_wr, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, init_done});
    end
    checks++;
    if ({dm_type, dm_addr, dm_wd, dm_pc, rsp0_rdata, rsp1_rdata} !== '0) begin
      fails++; $display("FAIL reset_bus: addr=%h wd=%h pc=%h type=%0d, want all 0", dm_addr, dm_wd, dm_pc, dm_type);
    end
    scramble = 1'b1;
    step();
    scramble = 1'b0;
    reset = 1'b1;
    while (!init_done && n < 3000) begin
      step(); n++;
      if (dm_wr) begin
        if (dm_addr !== 32'(idx * 4) || dm_wd !== 32'h0 || dm_type !== DM_w) bad++;
        idx++;
      end
    end
    ref_clear();
    checks++;
    if (idx != 1024) begin fails++; $display("FAIL init_write_count: got %0d want 1024", idx); end
    checks++;
    if (bad != 0) begin fails++; $display("FAIL init_write_seq: %0d bad beats, want 0", bad); end
    checks++;
    if (init_done !== 1'b1) begin fails++; $display("FAIL init_done: got %b want 1", init_done); end
    txn(1, 1'b0, DM_w, 32'h10, 32'h0, e, rd, lat, op, wrs);
    checks++;
    if (rd !== ref_load(DM_w, 32'h10) || e !== 1'b0) begin
      fails++; $display("FAIL post_init_load: rdata=%h err=%b want %h err=0", rd, e, ref_load(DM_w, 32'h10));
    end
  endtask

  task automatic test_arbitration();
    logic        pw [2];
    logic [31:0] pa [2];
    logic [31:0] pd [2];
    int          exp_w;
    logic [31:0] exp_rd;
    for (int q = 0; q < 2; q++) begin
      pw[q] = 1'($urandom); pa[q] = 32'h100 + 32'($urandom_range(0, 3)) * 4; pd[q] = $urandom;
      drive(q, 1'b1, pw[q], DM_w, pa[q], pd[q]);
    end
    #1;
    for (int r = 0; r < 4; r++) begin
      exp_w = mdl_last ? 0 : 1;
      checks++;
      if ({req1_ready, req0_ready} !== ((exp_w != 0) ? 2'b10 : 2'b01)) begin
        fails++; $display("FAIL arb_grant round %0d: ready1/0=%b%b want port %0d", r, req1_ready, req0_ready, exp_w);
      end
      exp_rd = pw[exp_w] ? 32'h0 : ref_load(DM_w, pa[exp_w]);
      if (pw[exp_w]) ref_store(DM_w, pa[exp_w], pd[exp_w]);
      mdl_last = (exp_w != 0);
      step();
      checks++;
      if ({req1_ready, req0_ready} !== 2'b00) begin
        fails++; $display("FAIL arb_ready_in_issue round %0d: got %b%b want 00", r, req1_ready, req0_ready);
      end
      pw[exp_w] = 1'($urandom); pa[exp_w] = 32'h100 + 32'($urandom_range(0, 3)) * 4; pd[exp_w] = $urandom;
      drive(exp_w, 1'b1, pw[exp_w], DM_w, pa[exp_w], pd[exp_w]);
      step();
      checks++;
      if (rspv(exp_w) !== 1'b1 || rspv(1 - exp_w) !== 1'b0 || rspd(exp_w) !== exp_rd) begin
        fails++; $display("FAIL arb_rsp round %0d: valid0/1=%b%b rdata=%h want port %0d rdata=%h",
          r, rsp0_valid, rsp1_valid, rspd(exp_w), exp_w, exp_rd);
      end
      step();
    end
    drive(0, 1'b0, 1'b0, DM_w, '0, '0);
    drive(1, 1'b0, 1'b0, DM_w, '0, '0);
    step();
  endtask

  task automatic test_store_load();
    logic e; logic [31:0] rd; int lat, wrs; bit op;
    txn(0, 1'b1, DM_w, 32'h20, 32'hDEADBEEF, e, rd, lat, op, wrs);
    ref_store(DM_w, 32'h20, 32'hDEADBEEF);
    checks++;
    if (lat != 2 || !op) begin fails++; $display("FAIL store_latency: got %0d single=%0b want 2 single=1", lat, op); end
    checks++;
    if (e !== 1'b0 || rd !== 32'h0 || wrs != 1) begin
      fails++; $display("FAIL store_rsp: err=%b rdata=%h writes=%0d want 0/00000000/1", e, rd, wrs);
    end
    txn(0, 1'b0, DM_b, 32'h23, 32'h0, e, rd, lat, op, wrs);
    checks++;
    if (rd !== 32'hFFFFFFDE || e !== 1'b0) begin fails++; $display("FAIL load_b: rdata=%h err=%b want ffffffde", rd, e); end
    txn(0, 1'b0, DM_bu, 32'h23, 32'h0, e, rd, lat, op, wrs);
    checks++;
    if (rd !== 32'h000000DE || e !== 1'b0) begin fails++; $display("FAIL load_bu: rdata=%h err=%b want 000000de", rd, e); end
  endtask

  task automatic test_errors();
    logic e; logic [31:0] rd; int lat, wrs; bit op;
    txn(1, 1'b1, DM_w, 32'h22, 32'hCAFEF00D, e, rd, lat, op, wrs);
    checks++;
    if (e !== 1'b1 || wrs != 0 || rd !== 32'h0) begin
      fails++; $display("FAIL err_store_w: err=%b writes=%0d rdata=%h want 1/0/0", e, wrs, rd);
    end
    txn(1, 1'b0, DM_h, 32'h21, 32'h0, e, rd, lat, op, wrs);
    checks++;
    if (e !== 1'b1 || wrs != 0 || rd !== 32'h0) begin
      fails++; $display("FAIL err_load_h: err=%b writes=%0d rdata=%h want 1/0/0", e, wrs, rd);
    end
    txn(1, 1'b0, DM_w, 32'h20, 32'h0, e, rd, lat, op, wrs);
    checks++;
    if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL err_mem_unchanged: rdata=%h want deadbeef", rd); end
  endtask

  task automatic test_random();
    logic e, we, exp_e; logic [31:0] rd, a, d, exp_rd; logic [2:0] ty; int lat, wrs, p; bit op;
    for (int i = 0; i < 24; i++) begin
      p = $urandom_range(0, 1);
      we = 1'($urandom);
      ty = 3'($urandom_range(0, 7));
      a = 32'h200 + 32'($urandom_range(0, 31));
      d = $urandom;
      exp_e = ref_err(we, ty, a);
      exp_rd = (we || exp_e) ? 32'h0 : ref_load(ty, a);
      txn(p, we, ty, a, d, e, rd, lat, op, wrs);
      if (we && !exp_e) ref_store(ty, a, d);
      checks++;
      if (e !== exp_e || rd !== exp_rd || lat != 2 || !op || wrs != ((we && !exp_e) ? 1 : 0)) begin
        fails++; $display("FAIL rand_txn %0d p%0d we=%b ty=%0d a=%h: err=%b rdata=%h lat=%0d wr=%0d want err=%b rdata=%h lat=2 wr=%0d",
          i, p, we, ty, a, e, rd, lat, wrs, exp_e, exp_rd, (we && !exp_e) ? 1 : 0);
      end
    end
  endtask

  task automatic test_reset_mid_txn();
    logic e; logic [31:0] rd; int lat, wrs, n = 0, w0, spurious = 0; bit op;
    drive(0, 1'b1, 1'b1, DM_w, 32'h40, 32'h12345678);
    #1;
    while (!req0_ready && n < 100) begin step(); n++; end
    step();
    drive(0, 1'b0, 1'b0, DM_w, '0, '0);
    w0 = wr_seen;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin step(); if (rsp0_valid || rsp1_valid) spurious++; end
    checks++;
    if (wr_seen - w0 != 0 || dm_wr !== 1'b0) begin
      fails++; $display("FAIL midtxn_write: writes=%0d dm_wr=%b want 0/0", wr_seen - w0, dm_wr);
    end
    reset = 1'b1;
    mdl_last = 1'b1;
    for (int i = 0; i < 3; i++) begin step(); if (rsp0_valid || rsp1_valid) spurious++; end
    checks++;
    if (spurious != 0) begin fails++; $display("FAIL midtxn_no_rsp: %0d response cycles want 0", spurious); end
    wait_init("midtxn");
    ref_clear();
    txn(0, 1'b0, DM_w, 32'h40, 32'h0, e, rd, lat, op, wrs);
    checks++;
    if (rd !== 32'h0 || e !== 1'b0) begin fails++; $display("FAIL midtxn_reload: rdata=%h err=%b want 0/0", rd, e); end
  endtask

  task automatic test_hold_during_init();
    int early = 0, n = 0;
    reset = 1'b0;
    drive(0, 1'b1, 1'b0, DM_w, 32'h44, 32'h0);
    step();
    reset = 1'b1;
    mdl_last = 1'b1;
    ref_clear();
    while (!init_done && n < 3000) begin
      if (req0_ready) early++;
      step(); n++;
    end
    checks++;
    if (early != 0) begin fails++; $display("FAIL init_ready_low: ready high %0d cycles in INIT want 0", early); end
    checks++;
    if (req0_ready !== 1'b1 || init_done !== 1'b1) begin
      fails++; $display("FAIL first_idle_grant: ready=%b init_done=%b want 1/1", req0_ready, init_done);
    end
    step();
    drive(0, 1'b0, 1'b0, DM_w, '0, '0);
    step();
    checks++;
    if (rsp0_valid !== 1'b1 || rsp0_rdata !== ref_load(DM_w, 32'h44) || rsp0_err !== 1'b0) begin
      fails++; $display("FAIL first_idle_rsp: valid=%b rdata=%h err=%b want 1/%h/0", rsp0_valid, rsp0_rdata, rsp0_err, ref_load(DM_w, 32'h44));
    end
    step();
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_store_load();
    test_errors();
    test_random();
    test_reset_mid_txn();
    test_hold_during_init();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/dm_ctrl.md
# dm_ctrl

Sequencer and two-port arbiter in front of the word-addressed data memory (`DM`). After reset it walks every word of memory writing zero, then grants single-beat load/store transactions from two requesters (port 0: pipeline MEM stage, port 1: debug/DMA). It rejects misaligned accesses and returns registered read data with a one-cycle response pulse.

## Interface
- `DEPTH`, 1024: memory depth in words; `DM` uses address bits [11:2].
- `INIT_CLEAR`, 1: 1 runs the zero-fill sequence after reset; 0 goes straight to IDLE.
- `clk`  in  1  the only clock.
- `reset`  in  1  asynchronous, active-low.
- `reqN_valid` / `reqN_ready`  in/out  1  request handshake, N∈{0,1}.
- `reqN_we`  in  1  1=store, 0=load.
- `reqN_type`  in  3  `DM_w`/`DM_h`/`DM_hu`/`DM_b`/`DM_bu`.
- `reqN_addr`, `reqN_wdata`, `reqN_pc`  in  32 each  byte address, store data, PC for the DM trace.
- `rspN_valid`  out  1  one-cycle response pulse.
- `rspN_err`  out  1  misaligned or illegal type; qualified by `rspN_valid`.
- `rspN_rdata`  out  32  load data; 0 for stores and errors.
- `dm_wr`, `dm_type`, `dm_addr`, `dm_wd`, `dm_pc`  out  1/3/32/32/32  drive `DM`.
- `dm_rdata`  in  32  `DM` combinational read output.
- `init_done`  out  1  high once zero-fill is complete.

## Operation
- States: INIT, IDLE, ISSUE, RESP.
- INIT: counter `cnt` runs 0..DEPTH-1.
  - `dm_wr`=1, `dm_type`=`DM_w`, `dm_addr`={cnt,2'b00}, `dm_wd`=0.
  - After the write with cnt=DEPTH-1: go to IDLE and set `init_done`.
  - Both `reqN_ready` are low in INIT.
- IDLE: `reqN_ready` = (state==IDLE) & grant-to-N.
  - Only one valid: that port is granted.
  - Both valid: the port ≠ `last_grant` wins.
  - On handshake: latch we/type/addr/wdata/pc and port id, update `last_grant`, go to ISSUE.
- ISSUE: drive `DM` from the latched registers.
  - `dm_wr` = latched we & !err.
  - At the cycle-ending edge: capture `dm_rdata` into the response register (forced 0 if store or err). Go to RESP.
- RESP: `rspP_valid`=1 for the latched port only, with `rspP_err` and `rspP_rdata`. Go to IDLE.
- err is decoded at latch time:
  - type not one of the five codes;
  - `DM_w` with addr[1:0]≠0;
  - `DM_h`/`DM_hu` with addr[0]≠0;
  - store with type `DM_hu`/`DM_bu`.
- Erroring requests never write memory.
- Outside INIT/ISSUE: `dm_wr`=0 and the `dm_*` buses hold their latched values.

## Timing
- Reset (asynchronous assert): state=INIT (IDLE if INIT_CLEAR=0), `cnt`=0, `last_grant`=1 (port 0 wins the first tie), `init_done`=0, all `reqN_ready`/`rspN_*`/`dm_wr`=0, `dm_*` buses=0.
- Reset deassertion is sampled synchronously.
- Reset mid-INIT restarts the fill from word 0.
- Reset mid-transaction drops that transaction: no response, write suppressed if not yet at the ISSUE edge. Requesters reissue.
- Zero-fill takes DEPTH cycles; `init_done` rises DEPTH cycles after the first active edge.
- Transaction latency: handshake at edge E → `DM` write/read sample at E+1 → `rsp_valid` high during the cycle after E+1 (two cycles after handshake).
- Throughput is one transaction per 3 cycles.
- `reqN_ready` is combinational from state and valids. Requesters must hold valid and payload until ready.
- No `reqN_ready` while in ISSUE/RESP.
- The fairness pointer updates only on grant. A single requester may be granted repeatedly.
- Response outputs are registered and free of combinational paths from `dm_rdata`.

## Structure
- Shared `const.v`: state codes `DMC_INIT`/`DMC_IDLE`/`DMC_ISSUE`/`DMC_RESP` and `DM_DEPTH`=1024, alongside the existing `DM_*` type codes.
- One sub-module `dm_rr_pick`: two-input round-robin picker (valid0, valid1, last → grant0, grant1).
- The alignment/type-legality check stays inline in `dm_ctrl`.

## Test plan
- Reset, hold both valids low.
  - `dm_wr`=1 for exactly 1024 cycles, addresses 0x000..0xFFC step 4, wd=0.
  - Then `init_done`=1; a later `DM_w` load of 0x10 returns 0.
- Port 0 `DM_w` store 0xDEADBEEF @0x20, then `DM_b` load @0x23 and `DM_bu` load @0x23.
  - Store response: `rsp0_valid` pulse 2 cycles after handshake, rdata=0.
  - Loads return 0xFFFFFFDE and 0x000000DE.
- Both ports valid in the same cycle, repeated 4 times.
  - Grants alternate 0,1,0,1; each response appears only on the granted port.
- Port 1 `DM_w` store @0x22, then `DM_h` load @0x21.
  - Both give `rsp1_err`=1, `dm_wr` stays 0, and memory at 0x20 is unchanged.
- Assert reset during ISSUE of a store 0x12345678 @0x40.
  - No response; after re-init, a load of @0x40 returns 0.
- Port 0 holds valid during INIT.
  - `req0_ready` stays 0 until `init_done`.
  - The handshake occurs in the first IDLE cycle.
